// File: rtl/timer_dev.sv
// timer_dev: bus-programmable 32-bit down-counter driving a level IRQ.
// Define TIMER_DEV_MODE1_EN to enable periodic (Mode 1) auto-reload.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q;
  logic        wr_ctrl, wr_pre;
  logic        en_now, periodic;

  assign wr_ctrl = We && (Addr == 2'd0);
  assign wr_pre  = We && (Addr == 2'd1);
  // IDLE reacts to an Enable write on the same edge it lands
  assign en_now  = wr_ctrl ? DIn[0] : ctrl_q[0];

`ifdef TIMER_DEV_MODE1_EN
  assign periodic = (ctrl_q[2:1] == 2'd1);
`else
  assign periodic = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    if (wr_ctrl || wr_pre) pend_d = 1'b0;
    if (wr_pre) preset_d = DIn;
    case (state_q)
      IDLE: begin
        if (en_now) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          pend_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (periodic) begin
          pend_d  = 1'b0;
          state_d = ctrl_q[0] ? LOAD : IDLE;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // bus write beats the hardware Enable clear
    if (wr_ctrl) ctrl_d = DIn[3:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= pend_d & ctrl_d[3];
    end
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      2'd0:    DOut = {28'd0, ctrl_q};
      2'd1:    DOut = preset_q;
      2'd2:    DOut = count_q;
      default: DOut = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed scenarios plus random bus traffic
// checked every cycle against a behavioural timer model.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        We = 1'b0;
  logic [31:0] DIn = '0;
  logic [31:0] DOut;
  logic        IRQ;

  int npass = 0;
  int ntot  = 0;
  int nfail = 0;

  // model: phase 0 idle, 1 load, 2 counting, 3 interrupt
  int          m_ph   = 0;
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_pre  = '0;
  logic [31:0] m_cnt  = '0;
  logic        m_pend = 1'b0;

  always #5 clk = ~clk;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .We    (We),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_dout(input logic [1:0] a);
    if (a == 2'd0) return {28'd0, m_ctrl};
    if (a == 2'd1) return m_pre;
    if (a == 2'd2) return m_cnt;
    return 32'd0;
  endfunction

  task automatic model_step();
    bit wc, wp, per, en;
    wc = We && (Addr == 2'd0);
    wp = We && (Addr == 2'd1);
    if (!reset) begin
      m_ph = 0; m_ctrl = '0; m_pre = '0; m_cnt = '0; m_pend = 1'b0;
      return;
    end
`ifdef TIMER_DEV_MODE1_EN
    per = (m_ctrl[2:1] == 2'd1);
`else
    per = 1'b0;
`endif
    en = m_ctrl[0];
    if (m_ph == 0) begin
      if (wc ? DIn[0] : en) m_ph = 1;
      if (wc || wp) m_pend = 1'b0;
    end else if (m_ph == 1) begin
      m_cnt = m_pre;
      m_ph = 2;
      if (wc || wp) m_pend = 1'b0;
    end else if (m_ph == 2) begin
      if (wc || wp) m_pend = 1'b0;
      if (!en) m_ph = 0;
      else if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin m_cnt = 0; m_pend = 1'b1; m_ph = 3; end
    end else begin
      if (wc || wp) m_pend = 1'b0;
      if (per) begin
        m_pend = 1'b0;
        m_ph = en ? 1 : 0;
      end else begin
        m_ctrl[0] = 1'b0;
        m_ph = 0;
      end
    end
    if (wp) m_pre = DIn;
    if (wc) m_ctrl = DIn[3:0];
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("irq_model", {31'd0, IRQ}, {31'd0, m_pend & m_ctrl[3]});
    check("dout_model", DOut, m_dout(Addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    We = 1'b1; Addr = a; DIn = d;
    cyc();
    We = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string tag);
    Addr = a;
    #1;
    check(tag, DOut, exp);
  endtask

  initial begin
    // reset
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    rd(2'd3, 32'd0, "rst_unused");
    check("rst_irq", {31'd0, IRQ}, 32'd0);

    // one-shot
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      rd(2'd2, 32'(6 - i), "os_count");
      check("os_irq", {31'd0, IRQ}, {31'd0, i == 6});
    end
    cyc();
    rd(2'd0, 32'h8, "os_ctrl_clr");
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("os_irq_hold", {31'd0, IRQ}, 32'd1);
    end
    wr(2'd0, 32'h8);
    check("os_irq_ack", {31'd0, IRQ}, 32'd0);

    // periodic
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int e = 1; e <= 17; e++) begin
      bit exp;
      cyc();
`ifdef TIMER_DEV_MODE1_EN
      exp = (e == 4) || (e == 9) || (e == 14);
`else
      exp = (e >= 4);
`endif
      check("per_irq", {31'd0, IRQ}, {31'd0, exp});
    end
    wr(2'd0, 32'h8);
    cyc(); cyc();
    check("per_stop_irq", {31'd0, IRQ}, 32'd0);

    // masked
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("mask_irq", {31'd0, IRQ}, 32'd0);
    end
    rd(2'd2, 32'd0, "mask_count");
    rd(2'd0, 32'd0, "mask_ctrl");
    wr(2'd0, 32'h8);
    cyc();
    check("mask_unmask_irq", {31'd0, IRQ}, 32'd0);

    // pause / resume
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 5; i++) cyc();
    rd(2'd2, 32'd6, "pause_at6");
    wr(2'd0, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      rd(2'd2, 32'd5, "pause_frozen");
    end
    wr(2'd0, 32'h9);
    rd(2'd2, 32'd5, "resume_load");
    cyc();
    rd(2'd2, 32'd10, "resume_reload");
    cyc();
    rd(2'd2, 32'd9, "resume_dec");
    wr(2'd0, 32'h0);
    cyc(); cyc();

    // reset mid-count
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    for (int i = 0; i < 5; i++) cyc();
    rd(2'd2, 32'd4, "rmid_at4");
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    rd(2'd0, 32'd0, "rmid_ctrl");
    rd(2'd1, 32'd0, "rmid_preset");
    rd(2'd2, 32'd0, "rmid_count");
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("rmid_no_irq", {31'd0, IRQ}, 32'd0);
    end

    // random traffic
    for (int k = 0; k < 800; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r < 2) ? 1'b0 : 1'b1;
      We = (r >= 2) && (r < 14);
      Addr = 2'($urandom_range(0, 3));
      if (Addr == 2'd1) DIn = 32'($urandom_range(0, 7));
      else DIn = $urandom;
      cyc();
    end
    We = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 Addr  input  2  register word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 We  input  1  bus write enable, sampled on the clk rising edge.
REQ-006 DIn  input  32  bus write data.
REQ-007 DOut  output  32  combinational read data for Addr.
REQ-008 IRQ  output  1  interrupt request to the CP0 HWInt input; registered, level.

Function
REQ-009 CTRL SHALL hold bit0 Enable, bits[2:1] Mode and bit3 IM; all other CTRL bits SHALL read 0.
REQ-010 PRESET SHALL be 32-bit read/write; COUNT SHALL be 32-bit read-only, and writes to Addr 2 or 3 SHALL be ignored.
REQ-011 DOut SHALL return {28'b0, CTRL[3:0]}, PRESET or COUNT for Addr 0, 1 or 2, and 0 for Addr 3.
REQ-012 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-013 IDLE: if Enable=1, the next state SHALL be LOAD; otherwise it SHALL stay IDLE with COUNT held.
REQ-014 LOAD: COUNT SHALL be loaded from PRESET and the next state SHALL be CNT.
REQ-015 CNT, Enable=0: the next state SHALL be IDLE and COUNT SHALL be frozen.
REQ-016 CNT, Enable=1, COUNT>1: COUNT SHALL decrement by 1 and the FSM SHALL stay in CNT.
REQ-017 CNT, Enable=1, COUNT<=1: COUNT SHALL become 0, the internal pending flag SHALL set to 1, and the next state SHALL be INT.
REQ-018 INT, Mode 0 (one-shot): Enable SHALL be cleared to 0 by hardware, the next state SHALL be IDLE, and pending SHALL stay 1.
REQ-019 INT, Mode 1 (periodic): pending SHALL clear, and the next state SHALL be LOAD, or IDLE if Enable=0.
REQ-020 Mode values 2 and 3 SHALL behave as Mode 0.
REQ-021 IRQ SHALL equal pending AND IM.
REQ-022 Mode 0: IRQ SHALL hold until any write to CTRL or PRESET, which clears pending.
REQ-023 Mode 1: IRQ SHALL be high for exactly the one INT cycle of each period.
REQ-024 Latency: with PRESET=N and a write of Enable=1 sampled on edge E0, IRQ SHALL rise after edge E(max(N,1)+1).
REQ-025 In Mode 1, IRQ SHALL then repeat every max(N,1)+2 cycles.
REQ-026 If a bus write to CTRL and a hardware Enable clear fall on the same edge, the bus write SHALL win.
REQ-027 A PRESET write during CNT SHALL NOT alter COUNT; the new value SHALL take effect at the next LOAD.
REQ-028 A write of Enable=0 during LOAD SHALL take effect on the next edge (CNT then goes to IDLE).
REQ-029 COUNT SHALL never wrap below 0; arithmetic is unsigned 32-bit.

Reset
REQ-030 While reset=0 at an edge, CTRL, PRESET, COUNT and pending SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-031 Reset SHALL take priority over bus writes and FSM activity, including mid-count and in INT.
REQ-032 After reset, IRQ=0 and DOut=0 for every Addr.

Configuration
REQ-033 The macro TIMER_DEV_MODE1_EN SHALL control periodic support.
REQ-034 With TIMER_DEV_MODE1_EN defined, Mode 1 SHALL behave per REQ-019, REQ-023 and REQ-025.
REQ-035 Without it, every Mode value SHALL behave as Mode 0, and CTRL[2:1] SHALL still be stored and read back.

Verification
REQ-036 Reset: hold reset=0 for 2 cycles, then read Addr 0/1/2 -> 0, 0, 0, and IRQ=0.
REQ-037 One-shot: PRESET=5, then CTRL=0x9 (Enable, IM, Mode 0).
  - IRQ SHALL rise after the 6th edge after the CTRL write; COUNT SHALL read 5,4,3,2,1,0.
  - CTRL SHALL then read 0x8, and IRQ SHALL stay high until a CTRL write of 0x8 clears it.
REQ-038 Periodic (macro on): PRESET=3, CTRL=0xB.
  - IRQ SHALL pulse 1 cycle wide, first after edge 4, then every 5 cycles, for 3 periods.
  - The same stimulus with the macro off SHALL give a single held IRQ.
REQ-039 Masking: PRESET=2, CTRL=0x1.
  - COUNT SHALL reach 0 with IRQ=0, and CTRL SHALL read 0x0.
  - A later write of CTRL=0x8 SHALL clear pending, so IRQ stays 0.
REQ-040 Pause/resume: PRESET=10, CTRL=0x9; write CTRL=0x8 when COUNT=6.
  - COUNT SHALL freeze at 5.
  - Writing CTRL=0x9 SHALL reload COUNT to 10 via LOAD.
REQ-041 Reset mid-count: PRESET=8, CTRL=0x9; pulse reset=0 when COUNT=4.
  - State SHALL go IDLE and all registers 0.
  - No IRQ SHALL follow within the next 20 cycles.
